// File: rtl/seed_random_3_card_dealer.sv
// Card dealer: round-robin arbitration over N_CH request channels, card ranks drawn from a
// free-running Galois LFSR with rejection sampling and a bounded-retry modulo fallback.
module seed_random_3_card_dealer #(
    parameter int unsigned              LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]        LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0]        SEED      = 16'hACE1,
    parameter int unsigned              N_CH      = 2,
    parameter int unsigned              CARD_MAX  = 13,
    parameter int unsigned              MAX_RETRY = 7,
    localparam int unsigned             CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk_cp_i,
    input  logic                 rst_cp_i,
    input  logic [N_CH-1:0]      req_card_i,
    input  logic                 seed_load_i,
    input  logic [LFSR_W-1:0]    seed_i,
    output logic                 card_valid_o,
    output logic [3:0]           card_o,
    output logic [CH_W-1:0]      card_ch_o,
    output logic [N_CH-1:0]      ack_o,
    output logic [1:0]           state_o,
    output logic [LFSR_W-1:0]    lfsr_o
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [3:0]          CARD_MAX_4  = 4'(CARD_MAX);
    localparam logic [RETRY_W-1:0]  MAX_RETRY_R = RETRY_W'(MAX_RETRY);
    localparam logic [CH_W-1:0]     LAST_CH     = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_SEND = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     grant_q, grant_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [3:0]          card_q, card_d;
    logic [CH_W-1:0]     card_ch_q, card_ch_d;
    logic                valid_q, valid_d;
    logic [N_CH-1:0]     ack_q, ack_d;

    logic [LFSR_W-1:0]   lfsr_step;
    logic                pick_found;
    logic [CH_W-1:0]     pick_idx;
    logic [3:0]          cand;
    logic                cand_ok;
    logic [3:0]          fallback;

    // LFSR free-runs every cycle; a seed load replaces the step, zero seeds map to SEED
    always_comb begin
        lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        lfsr_d    = lfsr_step;
        if (seed_load_i) begin
            lfsr_d = (seed_i == '0) ? SEED : seed_i;
        end
    end

    // Round-robin pick: first requester at or after rr_q, wrapping
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(rr_q) + i) % N_CH;
            if (!pick_found && req_card_i[CH_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        cand     = lfsr_q[3:0];
        cand_ok  = (cand != 4'd0) && (cand <= CARD_MAX_4);
        fallback = 4'((32'(cand) % CARD_MAX) + 32'd1);
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        retry_d   = retry_q;
        card_d    = card_q;
        card_ch_d = card_ch_q;
        valid_d   = 1'b0;
        ack_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    retry_d = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                if (cand_ok || (retry_q == MAX_RETRY_R)) begin
                    card_d    = cand_ok ? cand : fallback;
                    card_ch_d = grant_q;
                    valid_d   = 1'b1;
                    ack_d     = N_CH'(1) << grant_q;
                    state_d   = S_SEND;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            S_SEND: begin
                rr_d    = (grant_q == LAST_CH) ? '0 : grant_q + CH_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!req_card_i[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_cp_i) begin
        if (!rst_cp_i) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            rr_q      <= '0;
            grant_q   <= '0;
            retry_q   <= '0;
            card_q    <= '0;
            card_ch_q <= '0;
            valid_q   <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            retry_q   <= retry_d;
            card_q    <= card_d;
            card_ch_q <= card_ch_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
        end
    end

    assign card_valid_o = valid_q;
    assign card_o       = card_q;
    assign card_ch_o    = card_ch_q;
    assign ack_o        = ack_q;
    assign state_o      = state_q;
    assign lfsr_o       = lfsr_q;

endmodule
